// File: rtl/lockstep_cmp_param.sv
// Lockstep comparator: filters transient primary/redundant mismatches and reports faults.
// Optional triple-lane voting is enabled by defining LOCKSTEP_TMR_VOTE_EN.
module lockstep_cmp_param #(
  parameter int unsigned DATA_W       = 43,
  parameter int unsigned MISMATCH_TOL = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMP_EN,
  input  logic              ERR_CLR,
  input  logic [DATA_W-1:0] PRI_DATA,
  input  logic [DATA_W-1:0] RED_DATA,
`ifdef LOCKSTEP_TMR_VOTE_EN
  input  logic [DATA_W-1:0] TER_DATA,
  output logic [DATA_W-1:0] VOTED_DATA,
  output logic [1:0]        FAULT_LANE,
`endif
  output logic              DLS_ERROR,
  output logic              ERR_STICKY,
  output logic [CNT_W-1:0]  ERR_COUNT,
  output logic [DATA_W-1:0] ERR_SYNDROME
);

  localparam int unsigned RUN_W = $clog2(MISMATCH_TOL + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MISMATCH_TOL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_OFF, S_RUN, S_SUSPECT, S_FAULT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_cnt_nxt;
  logic [DATA_W-1:0] cand_syn;
  logic              cand_load_c;
  logic              all_eq_c;
  logic              mm_c;
  logic              fault_entry_c;
  logic [DATA_W-1:0] diff_c;
  logic [DATA_W-1:0] fault_syn_c;

`ifdef LOCKSTEP_TMR_VOTE_EN
  logic [1:0] lane_c;
  assign all_eq_c = (PRI_DATA == RED_DATA) && (RED_DATA == TER_DATA);

  // Identify the single lane that disagrees with the other two, if any
  always_comb begin
    lane_c = 2'b00;
    if ((RED_DATA == TER_DATA) && (PRI_DATA != RED_DATA))      lane_c = 2'b01;
    else if ((PRI_DATA == TER_DATA) && (RED_DATA != PRI_DATA)) lane_c = 2'b10;
    else if ((PRI_DATA == RED_DATA) && (TER_DATA != PRI_DATA)) lane_c = 2'b11;
  end
`else
  assign all_eq_c = (PRI_DATA == RED_DATA);
`endif

  assign mm_c        = CMP_EN & ~all_eq_c;
  assign diff_c      = PRI_DATA ^ RED_DATA;
  assign fault_syn_c = (MISMATCH_TOL == 1) ? diff_c : cand_syn;

  // Next-state and mismatch run counter
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    cand_load_c = 1'b0;
    case (state)
      S_OFF: begin
        run_cnt_nxt = '0;
        if (CMP_EN) state_nxt = S_RUN;
      end
      S_RUN: begin
        run_cnt_nxt = '0;
        if (mm_c) begin
          if (MISMATCH_TOL == 1) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt   = S_SUSPECT;
            run_cnt_nxt = RUN_W'(1);
            cand_load_c = 1'b1;
          end
        end else if (!CMP_EN) begin
          state_nxt = S_OFF;
        end
      end
      S_SUSPECT: begin
        if (mm_c) begin
          if (run_cnt == RUN_LAST) begin
            state_nxt   = S_FAULT;
            run_cnt_nxt = '0;
          end else begin
            run_cnt_nxt = run_cnt + RUN_W'(1);
          end
        end else begin
          run_cnt_nxt = '0;
          state_nxt   = CMP_EN ? S_RUN : S_OFF;
        end
      end
      S_FAULT: begin
        run_cnt_nxt = '0;
        if (all_eq_c) state_nxt = S_RUN;
      end
      default: begin
        state_nxt   = S_OFF;
        run_cnt_nxt = '0;
      end
    endcase
  end

  assign fault_entry_c = (state != S_FAULT) && (state_nxt == S_FAULT);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_OFF;
      run_cnt   <= '0;
      cand_syn  <= '0;
      DLS_ERROR <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_cnt_nxt;
      DLS_ERROR <= (state_nxt == S_FAULT);
      if (cand_load_c) cand_syn <= diff_c;
    end
  end

  // Fault history; a clear coinciding with an entry lets the entry win
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_STICKY   <= 1'b0;
      ERR_COUNT    <= '0;
      ERR_SYNDROME <= '0;
    end else if (fault_entry_c) begin
      ERR_STICKY <= 1'b1;
      if (ERR_CLR)                ERR_COUNT <= CNT_W'(1);
      else if (ERR_COUNT != CNT_MAX) ERR_COUNT <= ERR_COUNT + CNT_W'(1);
      if (ERR_CLR || !ERR_STICKY) ERR_SYNDROME <= fault_syn_c;
    end else if (ERR_CLR) begin
      ERR_STICKY   <= 1'b0;
      ERR_COUNT    <= '0;
      ERR_SYNDROME <= '0;
    end
  end

`ifdef LOCKSTEP_TMR_VOTE_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      VOTED_DATA <= '0;
      FAULT_LANE <= 2'b00;
    end else begin
      VOTED_DATA <= (PRI_DATA & RED_DATA) | (RED_DATA & TER_DATA) | (PRI_DATA & TER_DATA);
      if (fault_entry_c) FAULT_LANE <= lane_c;
      else if (ERR_CLR)  FAULT_LANE <= 2'b00;
    end
  end
`endif

endmodule

// File: tb/tb_lockstep_cmp_param.sv
// Bench for lockstep_cmp_param: directed table, corner sequences and random run vs a model.
// Define LOCKSTEP_TMR_VOTE_EN to exercise the voting build.
module tb_lockstep_cmp_param;
  localparam int unsigned DW  = 43;
  localparam int unsigned TOL = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned CWS = 2;

  logic clk;
  logic rst, en, clr;
  logic [DW-1:0] pri, red, ter;
  logic dls, sticky, dls_s, sticky_s;
  logic [CW-1:0]  count;
  logic [CWS-1:0] count_s;
  logic [DW-1:0]  syn, syn_s;
`ifdef LOCKSTEP_TMR_VOTE_EN
  logic [DW-1:0] voted, voted_s;
  logic [1:0]    lane, lane_s;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lockstep_cmp_param #(.DATA_W(DW), .MISMATCH_TOL(TOL), .CNT_W(CW)) dut (
    .HCLK(clk), .HRESET(rst), .CMP_EN(en), .ERR_CLR(clr),
    .PRI_DATA(pri), .RED_DATA(red),
`ifdef LOCKSTEP_TMR_VOTE_EN
    .TER_DATA(ter), .VOTED_DATA(voted), .FAULT_LANE(lane),
`endif
    .DLS_ERROR(dls), .ERR_STICKY(sticky), .ERR_COUNT(count), .ERR_SYNDROME(syn)
  );

  lockstep_cmp_param #(.DATA_W(DW), .MISMATCH_TOL(TOL), .CNT_W(CWS)) dut_sat (
    .HCLK(clk), .HRESET(rst), .CMP_EN(en), .ERR_CLR(clr),
    .PRI_DATA(pri), .RED_DATA(red),
`ifdef LOCKSTEP_TMR_VOTE_EN
    .TER_DATA(ter), .VOTED_DATA(voted_s), .FAULT_LANE(lane_s),
`endif
    .DLS_ERROR(dls_s), .ERR_STICKY(sticky_s), .ERR_COUNT(count_s), .ERR_SYNDROME(syn_s)
  );

  // Reference model: counts consecutive mismatches and keeps fault history
  bit            m_off = 1, m_fault = 0, m_sticky = 0;
  int            m_run = 0, m_cnt = 0, m_cnt_s = 0;
  logic [DW-1:0] m_cand = '0, m_syn = '0, m_voted = '0;
  logic [1:0]    m_lane = 2'b00;

  function automatic bit lanes_equal();
`ifdef LOCKSTEP_TMR_VOTE_EN
    return (pri == red) && (red == ter);
`else
    return pri == red;
`endif
  endfunction

  function automatic logic [1:0] odd_lane();
    if (red == ter && pri != red) return 2'b01;
    if (pri == ter && red != pri) return 2'b10;
    if (pri == red && ter != pri) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_step();
    bit eq, mm, entry;
    if (rst) begin
      m_off = 1; m_fault = 0; m_run = 0; m_cand = '0; m_sticky = 0;
      m_cnt = 0; m_cnt_s = 0; m_syn = '0; m_lane = 2'b00; m_voted = '0;
      return;
    end
    eq = lanes_equal();
    mm = en && !eq;
    entry = 0;
    for (int b = 0; b < int'(DW); b++)
      m_voted[b] = ((32'(pri[b]) + 32'(red[b]) + 32'(ter[b])) >= 2);
    if (m_fault) begin
      if (eq) m_fault = 0;
    end else if (m_off) begin
      if (en) m_off = 0;
    end else if (mm) begin
      if (m_run == 0) m_cand = pri ^ red;
      m_run++;
      if (m_run == int'(TOL)) begin
        entry = 1; m_fault = 1; m_run = 0;
      end
    end else begin
      m_run = 0;
      if (!en) m_off = 1;
    end
    if (clr) begin
      m_sticky = 0; m_cnt = 0; m_cnt_s = 0; m_syn = '0; m_lane = 2'b00;
    end
    if (entry) begin
      if (!m_sticky) m_syn = m_cand;
      m_sticky = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_cnt_s < (1 << CWS) - 1) m_cnt_s++;
      m_lane = odd_lane();
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic cyc(input bit r, input bit e, input bit c,
                     input logic [DW-1:0] p, input logic [DW-1:0] rd, input logic [DW-1:0] t);
    rst = r; en = e; clr = c; pri = p; red = rd; ter = t;
    @(posedge clk);
    model_step();
    #1;
    check("dls_error", 64'(dls), 64'(m_fault));
    check("err_sticky", 64'(sticky), 64'(m_sticky));
    check("err_count", 64'(count), 64'(m_cnt));
    check("err_syndrome", 64'(syn), 64'(m_syn));
    check("sat_count", 64'(count_s), 64'(m_cnt_s));
`ifdef LOCKSTEP_TMR_VOTE_EN
    check("voted_data", 64'(voted), 64'(m_voted));
    check("fault_lane", 64'(lane), 64'(m_lane));
`endif
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return DW'(v);
  endfunction

  typedef struct {
    bit            r, e, c;
    logic [DW-1:0] mask;
    bit            x_dls, x_sticky;
    int            x_cnt;
    logic [DW-1:0] x_syn;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit c, logic [DW-1:0] m,
                              bit d, bit s, int n, logic [DW-1:0] y);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.mask = m;
    v.x_dls = d; v.x_sticky = s; v.x_cnt = n; v.x_syn = y;
    return v;
  endfunction

  task automatic fault2(input logic [DW-1:0] m);
    logic [DW-1:0] p;
    p = rnd();
    cyc(0, 1, 0, p, p ^ m, p ^ m);
    cyc(0, 1, 0, p, p ^ m, p ^ m);
    p = rnd();
    cyc(0, 1, 0, p, p, p);
    cyc(0, 1, 0, p, p, p);
  endtask

  initial begin
    vec_t vt[$];
    logic [DW-1:0] p, m, rd, t;

    // Directed table: glitch filtering, fault entry, clear collision, enable and reset
    vt.push_back(mk(1, 1, 0, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(1, 1, 0, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h1, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h1, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h1, 1, 1, 1, 43'h1));
    vt.push_back(mk(0, 1, 0, 43'h0, 0, 1, 1, 43'h1));
    vt.push_back(mk(0, 1, 0, 43'h4, 0, 1, 1, 43'h1));
    vt.push_back(mk(0, 1, 1, 43'h4, 1, 1, 1, 43'h4));
    vt.push_back(mk(0, 1, 0, 43'h0, 0, 1, 1, 43'h4));
    vt.push_back(mk(0, 1, 1, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 0, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 0, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(1, 1, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h8, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h0, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h2, 0, 0, 0, 43'h0));
    vt.push_back(mk(0, 1, 0, 43'h2, 1, 1, 1, 43'h2));
    vt.push_back(mk(0, 0, 0, 43'h2, 1, 1, 1, 43'h2));
    vt.push_back(mk(0, 0, 0, 43'h0, 0, 1, 1, 43'h2));
    vt.push_back(mk(0, 0, 0, 43'h0, 0, 1, 1, 43'h2));

    for (int i = 0; i < vt.size(); i++) begin
      p = rnd();
      cyc(vt[i].r, vt[i].e, vt[i].c, p, p ^ vt[i].mask, p ^ vt[i].mask);
      check($sformatf("vec%0d_dls", i), 64'(dls), 64'(vt[i].x_dls));
      check($sformatf("vec%0d_sticky", i), 64'(sticky), 64'(vt[i].x_sticky));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].x_cnt));
      check($sformatf("vec%0d_syn", i), 64'(syn), 64'(vt[i].x_syn));
    end

    // Equal data for 1000 cycles never raises an error
    cyc(1, 1, 0, '0, '0, '0);
    cyc(1, 1, 0, '0, '0, '0);
    for (int i = 0; i < 1000; i++) begin
      p = rnd();
      cyc(0, 1, 0, p, p, p);
    end
    check("quiet_sticky", 64'(sticky), 64'(0));
    check("quiet_count", 64'(count), 64'(0));

    // Three faults keep the first syndrome; five saturate the 2-bit counter
    fault2(43'h100);
    fault2(43'h7_0000_0001);
    fault2(43'h400_0000_0000);
    check("three_count", 64'(count), 64'(3));
    check("three_syn", 64'(syn), 64'(43'h100));
    fault2(43'h20);
    fault2(43'h3);
    check("five_count", 64'(count), 64'(5));
    check("five_sat_count", 64'(count_s), 64'(3));

    // Disabled compare ignores persistent mismatch
    for (int i = 0; i < 50; i++) begin
      p = rnd();
      cyc(0, 0, 0, p, ~p, ~p);
    end
    check("disabled_dls", 64'(dls), 64'(0));
    check("disabled_count", 64'(count), 64'(5));

    // Reset while suspect discards the partial mismatch run
    p = rnd();
    cyc(0, 1, 0, p, p, p);
    cyc(0, 1, 0, p, p ^ 43'h10, p ^ 43'h10);
    cyc(1, 1, 0, p, p ^ 43'h10, p ^ 43'h10);
    check("rst_suspect_dls", 64'(dls), 64'(0));
    check("rst_suspect_count", 64'(count), 64'(0));
    cyc(0, 1, 0, p, p, p);
    cyc(0, 1, 0, p, p ^ 43'h10, p ^ 43'h10);
    cyc(0, 1, 0, p, p, p);
    check("rst_history_dls", 64'(dls), 64'(0));

`ifdef LOCKSTEP_TMR_VOTE_EN
    // Primary outvoted by redundant and tertiary lanes
    cyc(0, 1, 1, '0, '0, '0);
    cyc(0, 1, 0, '0, 43'h7FF_FFFF_FFFF, 43'h7FF_FFFF_FFFF);
    cyc(0, 1, 0, '0, 43'h7FF_FFFF_FFFF, 43'h7FF_FFFF_FFFF);
    check("tmr_voted", 64'(voted), 64'(43'h7FF_FFFF_FFFF));
    check("tmr_lane", 64'(lane), 64'(2'b01));
    check("tmr_dls", 64'(dls), 64'(1));
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      p = rnd();
      case ($urandom_range(0, 3))
        0, 1: m = '0;
        2: m = DW'(64'(1) << $urandom_range(0, DW - 1));
        default: m = rnd();
      endcase
      rd = p ^ m;
      case ($urandom_range(0, 5))
        0: t = p;
        1: t = rnd();
        default: t = rd;
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 49) == 0, p, rd, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
